fetch_stream_unit: RTL and testbench

- Instruction-fetch front stage directly upstream of the icache.
- Owns the fetch PC and issues block-address requests (with get2 when a fetch group crosses a cacheline) on the core-to-icache request channel.
- Matches in-order icache responses and extracts FETCH_WIDTH 32-bit instructions from the two returned lines.
- Buffers fetch groups in a credit-managed fetch queue toward decode, and handles redirects by epoch-based squashing.

---
 rtl/fetch_stream_unit.sv | 130 +++++++++++++
 tb/tb_fetch_stream_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stream_unit.sv
// rtl/fetch_stream_unit.sv - fetch PC owner, icache request/response matcher and fetch queue toward decode
module fetch_stream_unit #(
    parameter int              ADDR_W         = 64,
    parameter int              CACHELINE_SIZE = 64,
    parameter int              FETCH_WIDTH    = 4,
    parameter int              FQ_DEPTH       = 8,
    parameter int              MAX_INFLIGHT   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC     = 64'h8000_0000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    output logic                                          icache_req,
    input  logic                                          icache_gnt,
    output logic                                          icache_get2,
    output logic [ADDR_W-$clog2(CACHELINE_SIZE)-1:0]      icache_addr,
    input  logic                                          icache_rsp,
    input  logic [CACHELINE_SIZE*8-1:0]                   icache_line0,
    input  logic [CACHELINE_SIZE*8-1:0]                   icache_line1,
    input  logic                                          redirect_valid,
    input  logic [ADDR_W-1:0]                             redirect_pc,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [ADDR_W-1:0]                             out_pc,
    output logic [FETCH_WIDTH*32-1:0]                     out_inst
);
    localparam int OFF_W     = $clog2(CACHELINE_SIZE);
    localparam int GRP_BYTES = 4 * FETCH_WIDTH;
    localparam int INST_W    = FETCH_WIDTH * 32;
    localparam int LINE_W    = CACHELINE_SIZE * 8;
    localparam int IF_PW     = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int IF_CW     = $clog2(MAX_INFLIGHT + 1);
    localparam int FQ_PW     = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int FQ_CW     = $clog2(FQ_DEPTH + 1);
    localparam int SUM_W     = FQ_CW + 1;

    localparam logic [IF_PW-1:0] IF_LAST = IF_PW'(MAX_INFLIGHT - 1);
    localparam logic [FQ_PW-1:0] FQ_LAST = FQ_PW'(FQ_DEPTH - 1);
    localparam logic [IF_CW-1:0] IF_MAX  = IF_CW'(MAX_INFLIGHT);
    localparam logic [SUM_W-1:0] FQ_LIM  = SUM_W'(FQ_DEPTH);
    localparam logic [OFF_W:0]   GRP_B   = (OFF_W+1)'(GRP_BYTES);
    localparam logic [OFF_W:0]   LINE_B  = (OFF_W+1)'(CACHELINE_SIZE);

    logic [ADDR_W-1:0] pc;
    logic              epoch;
    logic [IF_CW-1:0]  inflight;
    logic [IF_PW-1:0]  if_wr, if_rd;
    logic [FQ_PW-1:0]  fq_wr, fq_rd;
    logic [FQ_CW-1:0]  fq_count;

    logic [ADDR_W-1:0] if_pc    [MAX_INFLIGHT];
    logic              if_epoch [MAX_INFLIGHT];
    logic [ADDR_W-1:0] fq_pc    [FQ_DEPTH];
    logic [INST_W-1:0] fq_inst  [FQ_DEPTH];

    logic                do_req, fq_push, fq_pop, credit_ok;
    logic [ADDR_W-1:0]   rsp_pc;
    logic [2*LINE_W-1:0] both_lines, shifted;
    logic [INST_W-1:0]   rsp_inst;

    always_comb begin
        credit_ok   = (inflight < IF_MAX) && ((SUM_W'(fq_count) + SUM_W'(inflight)) < FQ_LIM);
        icache_req  = rst && !redirect_valid && credit_ok;
        icache_addr = rst ? pc[ADDR_W-1:OFF_W] : '0;
        icache_get2 = rst && (((OFF_W+1)'(pc[OFF_W-1:0]) + GRP_B) > LINE_B);
        do_req      = icache_req && icache_gnt;

        // Group bytes are taken from the two-line window starting at the request's line offset.
        rsp_pc      = if_pc[if_rd];
        both_lines  = {icache_line1, icache_line0};
        shifted     = both_lines >> {rsp_pc[OFF_W-1:0], 3'b000};
        rsp_inst    = shifted[INST_W-1:0];

        out_valid   = (fq_count != '0);
        out_pc      = out_valid ? fq_pc[fq_rd] : '0;
        out_inst    = out_valid ? fq_inst[fq_rd] : '0;

        fq_push     = icache_rsp && !redirect_valid && (if_epoch[if_rd] == epoch);
        fq_pop      = out_valid && out_ready && !redirect_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            epoch    <= 1'b0;
            inflight <= '0;
            if_wr    <= '0;
            if_rd    <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else begin
            if (do_req)
                if_wr <= (if_wr == IF_LAST) ? '0 : if_wr + 1'b1;
            if (icache_rsp)
                if_rd <= (if_rd == IF_LAST) ? '0 : if_rd + 1'b1;
            inflight <= inflight + IF_CW'(do_req) - IF_CW'(icache_rsp);

            // In-flight entries keep their credits across a redirect; the epoch flip drops them later.
            if (redirect_valid) begin
                pc       <= redirect_pc;
                epoch    <= ~epoch;
                fq_wr    <= '0;
                fq_rd    <= '0;
                fq_count <= '0;
            end else begin
                if (do_req)
                    pc <= pc + ADDR_W'(GRP_BYTES);
                if (fq_push)
                    fq_wr <= (fq_wr == FQ_LAST) ? '0 : fq_wr + 1'b1;
                if (fq_pop)
                    fq_rd <= (fq_rd == FQ_LAST) ? '0 : fq_rd + 1'b1;
                fq_count <= fq_count + FQ_CW'(fq_push) - FQ_CW'(fq_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_req) begin
            if_pc[if_wr]    <= pc;
            if_epoch[if_wr] <= epoch;
        end
        if (fq_push) begin
            fq_pc[fq_wr]   <= rsp_pc;
            fq_inst[fq_wr] <= rsp_inst;
        end
    end

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst) icache_rsp |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_stream_unit.sv
// tb/tb_fetch_stream_unit.sv - randomized bench for fetch_stream_unit against a memory-level reference model
module tb_fetch_stream_unit;
    localparam int          MI  = 4;
    localparam int          FQD = 8;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_req, icache_gnt, icache_get2, icache_rsp;
    logic [57:0]  icache_addr;
    logic [511:0] icache_line0, icache_line1;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         out_valid, out_ready;
    logic [63:0]  out_pc;
    logic [127:0] out_inst;

    fetch_stream_unit dut (
        .clk            (clk),
        .rst            (rst),
        .icache_req     (icache_req),
        .icache_gnt     (icache_gnt),
        .icache_get2    (icache_get2),
        .icache_addr    (icache_addr),
        .icache_rsp     (icache_rsp),
        .icache_line0   (icache_line0),
        .icache_line1   (icache_line1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        int          gen;
        int          due;
        logic [57:0] blk;
        logic        get2;
    } req_t;

    req_t        pend[$];
    logic [63:0] m_fq[$];
    logic [63:0] m_pc;
    int          m_gen, cyc, last_due, lat_lo, lat_hi;
    int          n_cmp, n_mis;
    int          dut_grants, dut_deliv;
    logic [63:0] last_out_pc, first_out_pc;

    // Memory image: every byte address has a fixed pseudo-random value.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [63:0] h;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[63:56];
    endfunction

    function automatic logic [511:0] line_of(input logic [57:0] blk);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[8*i +: 8] = mem_byte({blk, 6'(i)});
        return l;
    endfunction

    function automatic logic [127:0] grp_of(input logic [63:0] pc);
        logic [127:0] g;
        for (int i = 0; i < 16; i++) g[8*i +: 8] = mem_byte(pc + 64'(i));
        return g;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   icache_req,  0);
        chk({tag, "_get2"},  icache_get2, 0);
        chk({tag, "_addr"},  icache_addr, 0);
        chk({tag, "_valid"}, out_valid,   0);
        chk({tag, "_pc"},    out_pc,      0);
        chk({tag, "_inst"},  out_inst,    0);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance the model, cross posedge.
    task automatic step(input int gp, input int rp, input logic rv, input logic [63:0] rpc);
        logic rsp_now, exp_req;
        req_t e;
        int   d;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_gnt     = ($urandom_range(0, 99) < gp);
        out_ready      = ($urandom_range(0, 99) < rp);
        rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
        icache_rsp     = rsp_now;
        if (rsp_now) begin
            icache_line0 = line_of(pend[0].blk);
            icache_line1 = pend[0].get2 ? line_of(pend[0].blk + 58'd1) : {16{$urandom()}};
        end else begin
            icache_line0 = {16{$urandom()}};
            icache_line1 = {16{$urandom()}};
        end
        #1;
        exp_req = !rv && (pend.size() < MI) && ((m_fq.size() + pend.size()) < FQD);
        chk("icache_req",  icache_req,  exp_req);
        chk("icache_addr", icache_addr, m_pc[63:6]);
        chk("icache_get2", icache_get2, (m_pc[5:0] + 16) > 64);
        chk("out_valid",   out_valid,   m_fq.size() != 0);
        if (m_fq.size() != 0) begin
            chk("out_pc",   out_pc,   m_fq[0]);
            chk("out_inst", out_inst, grp_of(m_fq[0]));
        end
        if (icache_req && icache_gnt) dut_grants++;
        if (out_valid && out_ready && !rv) begin
            if (dut_deliv == 0) first_out_pc = out_pc;
            dut_deliv++;
            last_out_pc = out_pc;
        end
        if (rv) begin
            if (rsp_now) e = pend.pop_front();
            m_fq.delete();
            m_pc = rpc;
            m_gen++;
        end else begin
            if (m_fq.size() != 0 && out_ready) void'(m_fq.pop_front());
            if (rsp_now) begin
                e = pend.pop_front();
                if (e.gen == m_gen) m_fq.push_back(e.pc);
            end
            if (exp_req && icache_gnt) begin
                e.pc   = m_pc;
                e.gen  = m_gen;
                e.blk  = icache_addr;
                e.get2 = icache_get2;
                d = cyc + $urandom_range(lat_lo, lat_hi);
                if (d <= last_due) d = last_due + 1;
                e.due    = d;
                last_due = d;
                pend.push_back(e);
                m_pc = m_pc + 64'd16;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pend.size() != 0; i++) step(0, 100, 1'b0, 64'd0);
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; cyc = 0; last_due = 0; m_gen = 0;
        lat_lo = 2; lat_hi = 2; m_pc = RPC;
        dut_grants = 0; dut_deliv = 0; last_out_pc = '0; first_out_pc = '0;
        rst = 1'b0; icache_gnt = 1'b0; icache_rsp = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0; icache_line0 = '0; icache_line1 = '0;
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // Backpressure from reset: exactly FQ_DEPTH grants, then in-order drain.
        repeat (20) step(100, 0, 1'b0, 64'd0);
        chk("bp_grants", dut_grants, 8);
        chk("bp_req_low", icache_req, 0);
        repeat (12) step(0, 100, 1'b0, 64'd0);
        chk("bp_delivered", dut_deliv, 8);
        chk("bp_last_pc", last_out_pc, RPC + 64'h70);

        repeat (300) step(60, 70, 1'b0, 64'd0);

        // Cacheline-crossing group.
        drain();
        step(0, 100, 1'b1, 64'h8000_0038);
        chk("cross_addr", icache_addr, 58'h200_0000);
        chk("cross_get2", icache_get2, 1);
        repeat (8) step(100, 100, 1'b0, 64'd0);

        // Redirect with two requests in flight.
        drain();
        repeat (2) step(100, 0, 1'b0, 64'd0);
        step(0, 100, 1'b1, 64'h8000_1000);
        dut_deliv = 0;
        repeat (10) step(100, 100, 1'b0, 64'd0);
        chk("redir_first_pc", first_out_pc, 64'h8000_1000);

        // Back-to-back redirects.
        repeat (2) step(100, 100, 1'b0, 64'd0);
        step(0, 100, 1'b1, 64'h8000_2000);
        step(0, 100, 1'b1, 64'h8000_3008);
        dut_deliv = 0;
        repeat (12) step(100, 100, 1'b0, 64'd0);
        chk("b2b_first_pc", first_out_pc, 64'h8000_3008);

        // PC wrap across the top of the address space.
        step(0, 100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (8) step(100, 100, 1'b0, 64'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(60, 70, 1'b1, {48'h0000_0000_8000, 14'($urandom()), 2'b00});
            else
                step(60, 70, 1'b0, 64'd0);
        end

        // Variable, in-order response latency.
        drain();
        lat_lo = 2; lat_hi = 6;
        repeat (300) step(70, 60, 1'b0, 64'd0);
        drain();
        lat_lo = 6; lat_hi = 6;

        // Asynchronous reset with three requests outstanding.
        repeat (3) step(100, 0, 1'b0, 64'd0);
        icache_gnt = 1'b0; icache_rsp = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        pend.delete();
        m_fq.delete();
        m_pc = RPC;
        lat_lo = 2; lat_hi = 2;
        @(posedge clk);
        cyc++;
        last_due = cyc;
        @(negedge clk);
        rst = 1'b1;
        dut_deliv = 0;
        repeat (10) step(100, 100, 1'b0, 64'd0);
        chk("restart_first_pc", first_out_pc, RPC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
